// File: rtl/astra_bus_pkg.sv
// Shared encodings for the memory bus arbiter: RW polarity, read-return owner tag
// and arbiter state.
package astra_bus_pkg;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    typedef enum logic {
        CPU_PRI   = 1'b0,
        DMA_BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/arb_starve_timer.sv
// DMA starvation guard: counts denied DMA request cycles, then holds a bounded
// forced DMA burst. force_dma tells the grant logic to lock out the core.
module arb_starve_timer
    import astra_bus_pkg::*;
#(
    parameter int DMA_WAIT_MAX  = 8,
    parameter int DMA_MAX_BURST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic dma_req,
    input  logic dma_gnt,
    output logic force_dma
);

    localparam int SW = $clog2(DMA_WAIT_MAX + 1);
    localparam int BW = $clog2(DMA_MAX_BURST + 1);
    localparam logic [SW-1:0] STARVE_LAST = SW'(DMA_WAIT_MAX - 1);
    localparam logic [SW-1:0] STARVE_SAT  = SW'(DMA_WAIT_MAX);
    localparam logic [BW-1:0] BURST_LAST  = BW'(DMA_MAX_BURST - 1);

    arb_state_e    state, state_n;
    logic [SW-1:0] starve_cnt, starve_n;
    logic [BW-1:0] burst_cnt, burst_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CPU_PRI;
            starve_cnt <= '0;
            burst_cnt  <= '0;
        end else begin
            state      <= state_n;
            starve_cnt <= starve_n;
            burst_cnt  <= burst_n;
        end
    end

    always_comb begin
        state_n  = state;
        starve_n = starve_cnt;
        burst_n  = burst_cnt;
        unique case (state)
            CPU_PRI: begin
                if (dma_req && !dma_gnt) begin
                    // Switch on the edge where the count would reach the limit.
                    if (starve_cnt >= STARVE_LAST) begin
                        state_n  = DMA_BURST;
                        starve_n = STARVE_SAT;
                        burst_n  = '0;
                    end else begin
                        starve_n = starve_cnt + 1'b1;
                    end
                end else begin
                    starve_n = '0;
                end
            end
            DMA_BURST: begin
                starve_n = '0;
                if (!dma_req) begin
                    state_n = CPU_PRI;
                end else if (dma_gnt) begin
                    burst_n = burst_cnt + 1'b1;
                    if (burst_cnt >= BURST_LAST) begin
                        state_n = CPU_PRI;
                    end
                end
            end
            default: state_n = CPU_PRI;
        endcase
    end

    assign force_dma = (state == DMA_BURST) && dma_req;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single synchronous RAM port between the 6502 core and a DMA
// requester; read data returns one cycle after grant, routed to the owning port.
module mem_bus_arbiter
    import astra_bus_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 8,
    parameter int DMA_WAIT_MAX  = 8,
    parameter int DMA_MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_rw,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_ad,
    output logic              mem_rw,
    output logic [DATA_W-1:0] mem_dout,
    input  logic [DATA_W-1:0] mem_din
);

    logic              force_dma;
    logic              rd_pending;
    owner_e            rd_owner;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;

    arb_starve_timer #(
        .DMA_WAIT_MAX (DMA_WAIT_MAX),
        .DMA_MAX_BURST(DMA_MAX_BURST)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .dma_req  (dma_req),
        .dma_gnt  (dma_gnt),
        .force_dma(force_dma)
    );

    // A burst without a pending DMA request falls straight through to the core.
    always_comb begin
        cpu_gnt = !rst && cpu_req && !force_dma;
        dma_gnt = !rst && dma_req && !cpu_gnt;
    end

    always_comb begin
        mem_ad   = cpu_addr;
        mem_rw   = RW_READ;
        mem_dout = '0;
        if (cpu_gnt) begin
            mem_rw   = cpu_rw;
            mem_dout = cpu_wdata;
        end else if (dma_gnt) begin
            mem_ad   = dma_addr;
            mem_rw   = dma_rw;
            mem_dout = dma_wdata;
        end
    end

    always_comb begin
        cpu_rvalid = !rst && rd_pending && (rd_owner == OWN_CPU);
        dma_rvalid = !rst && rd_pending && (rd_owner == OWN_DMA);
        cpu_rdata  = rst ? '0 : (cpu_rvalid ? mem_din : cpu_rdata_q);
        dma_rdata  = rst ? '0 : (dma_rvalid ? mem_din : dma_rdata_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pending  <= 1'b0;
            rd_owner    <= OWN_CPU;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            rd_pending <= (cpu_gnt && cpu_rw == RW_READ) || (dma_gnt && dma_rw == RW_READ);
            rd_owner   <= dma_gnt ? OWN_DMA : OWN_CPU;
            if (cpu_rvalid) cpu_rdata_q <= mem_din;
            if (dma_rvalid) dma_rdata_q <= mem_din;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: per-cycle grant/bus expectations and
// read-return expectations are queued at issue time and checked by a monitor.
module tb_mem_bus_arbiter;
    import astra_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_rw, cpu_gnt, cpu_rvalid;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        dma_req, dma_rw, dma_gnt, dma_rvalid;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata, dma_rdata;
    logic [15:0] mem_ad;
    logic        mem_rw;
    logic [7:0]  mem_dout, mem_din;

    logic [7:0]  ram [0:65535];

    int total = 0;
    int bad   = 0;
    bit done  = 1'b0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_W       (16),
        .DATA_W       (8),
        .DMA_WAIT_MAX (8),
        .DMA_MAX_BURST(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_rw    (cpu_rw),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_rvalid(cpu_rvalid),
        .cpu_rdata (cpu_rdata),
        .dma_req   (dma_req),
        .dma_rw    (dma_rw),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_gnt   (dma_gnt),
        .dma_rvalid(dma_rvalid),
        .dma_rdata (dma_rdata),
        .mem_ad    (mem_ad),
        .mem_rw    (mem_rw),
        .mem_dout  (mem_dout),
        .mem_din   (mem_din)
    );

    // Synchronous RAM: data for an address appears one cycle later.
    always @(posedge clk) begin
        if (mem_rw == RW_WRITE) ram[mem_ad] <= mem_dout;
        mem_din <= ram[mem_ad];
    end

    typedef struct {
        bit          rst;
        bit          cr, crw;
        logic [15:0] ca;
        logic [7:0]  cd;
        bit          dr, drw;
        logic [15:0] da;
        logic [7:0]  dd;
        bit          eg_c, eg_d;
        logic [15:0] e_ad;
        bit          e_rw;
        logic [7:0]  e_dout;
        logic [7:0]  e_crd, e_drd;
        int          rv;
        logic [7:0]  rd;
    } vec_t;

    typedef struct {
        int         rv;
        logic [7:0] rd;
    } rd_exp_t;

    vec_t    vecs[$];
    vec_t    cyc_q[$];
    rd_exp_t rd_q[$];

    int          prev_rd = 0;
    logic [15:0] prev_addr = '0;
    logic [7:0]  hold_c = '0;
    logic [7:0]  hold_d = '0;

    function automatic logic [7:0] exp_mem(input logic [15:0] a);
        case (a)
            16'h1234: return 8'hA5;
            16'h0010: return 8'h11;
            16'h0020: return 8'h22;
            default:  return 8'h00;
        endcase
    endfunction

    task automatic add(input bit r, input bit cr, input bit crw, input logic [15:0] ca,
                       input logic [7:0] cd, input bit dr, input bit drw,
                       input logic [15:0] da, input logic [7:0] dd,
                       input bit eg_c, input bit eg_d);
        vec_t v;
        v.rst = r; v.cr = cr; v.crw = crw; v.ca = ca; v.cd = cd;
        v.dr = dr; v.drw = drw; v.da = da; v.dd = dd;
        v.eg_c = eg_c; v.eg_d = eg_d;
        if (eg_c) begin
            v.e_ad = ca; v.e_rw = crw; v.e_dout = cd;
        end else if (eg_d) begin
            v.e_ad = da; v.e_rw = drw; v.e_dout = dd;
        end else begin
            v.e_ad = ca; v.e_rw = 1'b1; v.e_dout = 8'h00;
        end
        v.rv = r ? 0 : prev_rd;
        v.rd = exp_mem(prev_addr);
        if (r) begin
            hold_c = '0; hold_d = '0;
        end else if (v.rv == 1) begin
            hold_c = v.rd;
        end else if (v.rv == 2) begin
            hold_d = v.rd;
        end
        v.e_crd = hold_c;
        v.e_drd = hold_d;
        if (!r && eg_c && crw) begin
            prev_rd = 1; prev_addr = ca;
        end else if (!r && eg_d && drw) begin
            prev_rd = 2; prev_addr = da;
        end else begin
            prev_rd = 0;
        end
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle grant/bus/rdata check, read returns popped on rvalid.
    initial begin
        vec_t    e;
        rd_exp_t r;
        forever begin
            @(negedge clk);
            if (done) break;
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                chk("gnt", {30'd0, cpu_gnt, dma_gnt}, {30'd0, e.eg_c, e.eg_d});
                chk("bus", {7'd0, mem_ad, mem_rw, mem_dout}, {7'd0, e.e_ad, e.e_rw, e.e_dout});
                chk("rdata_hold", {16'd0, cpu_rdata, dma_rdata}, {16'd0, e.e_crd, e.e_drd});
            end
            if (cpu_rvalid || dma_rvalid) begin
                if (rd_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rv_unexpected: got cpu_rvalid=%0b dma_rvalid=%0b want none",
                             cpu_rvalid, dma_rvalid);
                end else begin
                    r = rd_q.pop_front();
                    chk("rv_port", {30'd0, cpu_rvalid, dma_rvalid},
                        (r.rv == 1) ? 32'd2 : 32'd1);
                    chk("rv_data", {24'd0, (r.rv == 1) ? cpu_rdata : dma_rdata}, {24'd0, r.rd});
                end
            end
        end
    end

    initial begin
        rd_exp_t r;
        for (int unsigned a = 0; a < 65536; a++) ram[a] = 8'h00;
        ram[16'h1234] = 8'hA5;
        ram[16'h0010] = 8'h11;
        ram[16'h0020] = 8'h22;
        mem_din = '0;
        rst = 1'b1;
        cpu_req = 1'b0; cpu_rw = 1'b1; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_rw = 1'b1; dma_addr = '0; dma_wdata = '0;

        // Reset held with both requesters active
        repeat (3) add(1, 1, RW_READ, 16'h1234, 8'h00, 1, RW_WRITE, 16'h0300, 8'h77, 0, 0);
        // First cycle out of reset goes to the core; DMA takes the next
        add(0, 1, RW_READ, 16'h1234, 8'h00, 1, RW_WRITE, 16'h0300, 8'h77, 1, 0);
        add(0, 0, RW_READ, 16'h1234, 8'h00, 1, RW_WRITE, 16'h0300, 8'h77, 0, 1);
        add(0, 0, RW_READ, 16'h0000, 8'h00, 0, RW_READ, 16'h0000, 8'h00, 0, 0);
        // CPU-only read
        add(0, 1, RW_READ, 16'h1234, 8'h00, 0, RW_READ, 16'h0000, 8'h00, 1, 0);
        add(0, 0, RW_READ, 16'h0000, 8'h00, 0, RW_READ, 16'h0000, 8'h00, 0, 0);
        // DMA-only write
        add(0, 0, RW_READ, 16'h0000, 8'h00, 1, RW_WRITE, 16'h0200, 8'h3C, 0, 1);
        add(0, 0, RW_READ, 16'h0000, 8'h00, 0, RW_READ, 16'h0000, 8'h00, 0, 0);
        // Continuous contention: 8 core, 4 forced DMA, repeated
        for (int i = 0; i < 24; i++)
            add(0, 1, RW_READ, 16'h0010, 8'h00, 1, RW_WRITE, 16'h0210, 8'h5A,
                (i % 12) < 8, (i % 12) >= 8);
        // Forced burst cut short after 2 grants: core granted the same cycle
        for (int i = 0; i < 10; i++)
            add(0, 1, RW_READ, 16'h0010, 8'h00, 1, RW_WRITE, 16'h0210, 8'h5A, i < 8, i >= 8);
        add(0, 1, RW_READ, 16'h0010, 8'h00, 0, RW_WRITE, 16'h0210, 8'h5A, 1, 0);
        // Starve count restarted from zero: a full 8 core grants again
        for (int i = 0; i < 9; i++)
            add(0, 1, RW_READ, 16'h0010, 8'h00, 1, RW_WRITE, 16'h0210, 8'h5A, i < 8, i == 8);
        add(0, 1, RW_READ, 16'h0010, 8'h00, 0, RW_WRITE, 16'h0210, 8'h5A, 1, 0);
        add(0, 0, RW_READ, 16'h0000, 8'h00, 0, RW_READ, 16'h0000, 8'h00, 0, 0);
        // Alternating reads with a reset pulse while a read is in flight
        add(0, 1, RW_READ, 16'h0010, 8'h00, 0, RW_READ, 16'h0020, 8'h00, 1, 0);
        add(0, 0, RW_READ, 16'h0010, 8'h00, 1, RW_READ, 16'h0020, 8'h00, 0, 1);
        add(0, 1, RW_READ, 16'h0010, 8'h00, 0, RW_READ, 16'h0020, 8'h00, 1, 0);
        add(1, 1, RW_READ, 16'h0010, 8'h00, 1, RW_READ, 16'h0020, 8'h00, 0, 0);
        add(0, 0, RW_READ, 16'h0010, 8'h00, 1, RW_READ, 16'h0020, 8'h00, 0, 1);
        add(0, 1, RW_READ, 16'h0010, 8'h00, 0, RW_READ, 16'h0020, 8'h00, 1, 0);
        add(0, 0, RW_READ, 16'h0000, 8'h00, 0, RW_READ, 16'h0000, 8'h00, 0, 0);
        add(0, 0, RW_READ, 16'h0000, 8'h00, 0, RW_READ, 16'h0000, 8'h00, 0, 0);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            rst       = vecs[i].rst;
            cpu_req   = vecs[i].cr;
            cpu_rw    = vecs[i].crw;
            cpu_addr  = vecs[i].ca;
            cpu_wdata = vecs[i].cd;
            dma_req   = vecs[i].dr;
            dma_rw    = vecs[i].drw;
            dma_addr  = vecs[i].da;
            dma_wdata = vecs[i].dd;
            cyc_q.push_back(vecs[i]);
            if (vecs[i].rv != 0) begin
                r.rv = vecs[i].rv;
                r.rd = vecs[i].rd;
                rd_q.push_back(r);
            end
        end
        repeat (3) @(posedge clk);
        while (rd_q.size() > 0) begin
            r = rd_q.pop_front();
            total++; bad++;
            $display("FAIL rv_missing: got no rvalid want port %0d data %0h", r.rv, r.rd);
        end
        done = 1'b1;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
